fpsu_ret_collect: RTL and testbench
===================================

FPSU_RET_COLLECT -- requirements
Module: fpsu_ret_collect

Interface
REQ-001: Parameter DEPTH, 8, number of retire-queue entries; power of two, at least 4.
REQ-002: Parameter W, 14, width of one retire word.
REQ-003: clk  input  1  single clock; all state updates on posedge clk, or on negedge when swapedge is defined.
REQ-004: rst  input  1  reset, asynchronous and active-low.
REQ-005: in_ret0 / in_ret1 / in_ret2  input  W each  retire words from FP ports u1 / u3 / u5.
REQ-006: in_en0 / in_en1 / in_en2  input  1 each  retire-word valid for ports u1 / u3 / u5.
REQ-007: out_ret0 / out_ret1  output  W each  oldest and second-oldest queued words.
REQ-008: out_vld0 / out_vld1  output  1 each  out_ret0 / out_ret1 hold valid entries.
REQ-009: out_rdy  input  1  consumer takes every presented valid word this cycle.
REQ-010: stall  output  1  upstream hold request.
REQ-011: count  output  log2(DEPTH)+1  current occupancy.
REQ-012: ovf  output  1  sticky overflow flag.
REQ-013: clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-014: Storage is a circular buffer of DEPTH words with a read pointer, a write pointer and an occupancy counter; all three are registered.
REQ-015: Enqueue order each cycle is port order u1, u3, u5, compressed so that only enabled ports consume slots.
REQ-016: Dequeue count ndeq is 0 when out_rdy=0; otherwise ndeq = min(count, 2).
REQ-017: Space available for enqueue is DEPTH - count + ndeq, so a same-cycle dequeue frees slots for that cycle's enqueue.
REQ-018: When more words are enabled than there is space, words are accepted in port order until the buffer is full; the excess words are dropped and ovf is set next cycle.
REQ-019: count_next = count + nacc - ndeq, where nacc is the number of accepted words (0..3).
REQ-020: Pointers are incremented modulo DEPTH and wrap without a gap.
REQ-021: out_vld0 = (count >= 1) and out_vld1 = (count >= 2); out_ret0 / out_ret1 come from the read pointer and read pointer+1, taken from registers only.
REQ-022: There is no bypass path: a word enqueued in cycle N is visible on the outputs in cycle N+1 at the earliest.
REQ-023: When out_vld=0, the corresponding out_ret is all zero.
REQ-024: stall = (count > DEPTH-3), registered from count_next, so that one cycle of in-flight writes still fits.
REQ-025: ovf sets on any drop and holds until clr_ovf=1 or reset; when a drop and clr_ovf occur in the same cycle, ovf stays 1.
REQ-026: Retire words are opaque and stored unmodified; the block performs no arithmetic on their contents.

Reset
REQ-027: While rst=0, the pointers, count, stall, ovf and all storage words are asynchronously 0, and out_vld0 = out_vld1 = 0.
REQ-028: Reset asserted mid-operation discards all queued words; no word is presented after rst is released until a new enqueue occurs.
REQ-029: The first enqueue is accepted on the first active clock edge after rst rises.

Verification
REQ-030: After reset, in_en0=in_en2=1 (in_ret0=0x0011, in_ret2=0x0033), in_en1=0, out_rdy=0 -> next cycle count=2, out_ret0=0x0011, out_ret1=0x0033, out_vld0=out_vld1=1.
REQ-031: With count=7 and out_rdy=0, all three ports enabled (0x0A, 0x0B, 0x0C) -> 0x0A accepted, 0x0B and 0x0C dropped, count=8, ovf=1, stall=1.
REQ-032: With count=8 and out_rdy=1, three ports enabled -> 2 words dequeued, 2 accepted in port order, 1 dropped, count stays 8, ovf=1.
REQ-033: Stream 20 single-word enqueues with out_rdy=1 every cycle -> words emerge in order with 1-cycle latency, pointers wrap past 7->0 without loss, count never exceeds 1, ovf stays 0.
REQ-034: With count=5 and words queued, rst pulsed low between clock edges -> count=0, out_vld0=0 and stall=0 immediately; no old word ever appears after rst rises.
REQ-035: With ovf=1, clr_ovf=1 in a cycle with no drop -> ovf=0 next cycle; clr_ovf=1 in a cycle with a drop -> ovf remains 1.

Source files
------------

// File: rtl/fpsu_ret_collect_if.sv
`default_nettype none
// =============================================================================
// Module : fpsu_ret_collect_if
// Brief  : Retire-port / retire-queue bundle between the FP ports and consumer.
// Rev    : 1.0  initial release
// =============================================================================
interface fpsu_ret_collect_if #(
   parameter int DEPTH = 8,
   parameter int W     = 14
);
   localparam int c_CW = $clog2(DEPTH) + 1;

   logic [W-1:0]    in_ret0;
   logic [W-1:0]    in_ret1;
   logic [W-1:0]    in_ret2;
   logic            in_en0;
   logic            in_en1;
   logic            in_en2;
   logic [W-1:0]    out_ret0;
   logic [W-1:0]    out_ret1;
   logic            out_vld0;
   logic            out_vld1;
   logic            out_rdy;
   logic            stall;
   logic [c_CW-1:0] count;
   logic            ovf;
   logic            clr_ovf;

   modport master (
      output in_ret0, in_ret1, in_ret2, in_en0, in_en1, in_en2, out_rdy, clr_ovf,
      input  out_ret0, out_ret1, out_vld0, out_vld1, stall, count, ovf
   );

   modport slave (
      input  in_ret0, in_ret1, in_ret2, in_en0, in_en1, in_en2, out_rdy, clr_ovf,
      output out_ret0, out_ret1, out_vld0, out_vld1, stall, count, ovf
   );
endinterface
`default_nettype wire

// File: rtl/fpsu_ret_collect.sv
`default_nettype none
// =============================================================================
// Module : fpsu_ret_collect
// Brief  : Collects up to three retire words per cycle into a circular queue
//          and presents the two oldest entries to the consumer.
// Rev    : 1.0  initial release
// =============================================================================
module fpsu_ret_collect #(
   parameter int DEPTH = 8,
   parameter int W     = 14
) (
   input  logic                clk,
   input  logic                rst,
   fpsu_ret_collect_if.slave   bus
);
   localparam int unsigned     c_AW        = $clog2(DEPTH);
   localparam int unsigned     c_CW        = c_AW + 1;
   localparam logic [c_CW-1:0] c_ONE       = {{(c_CW-1){1'b0}}, 1'b1};
   localparam logic [c_CW-1:0] c_TWO       = {{(c_CW-2){1'b0}}, 2'd2};
   localparam logic [c_CW-1:0] c_DEPTH_CNT = DEPTH[c_CW-1:0];
   localparam logic [c_CW-1:0] c_STALL_TH  = c_DEPTH_CNT - {{(c_CW-2){1'b0}}, 2'd3};
   localparam logic [c_AW-1:0] c_PTR_ONE   = {{(c_AW-1){1'b0}}, 1'b1};

   logic [W-1:0]    r_mem [DEPTH];
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_CW-1:0] r_count;
   logic            r_stall;
   logic            r_ovf;

   logic [2:0]      w_en;
   logic [W-1:0]    w_wdata [3];
   logic [2:0]      w_wen;
   logic [c_AW-1:0] w_waddr [3];
   logic [c_CW-1:0] w_ndeq;
   logic [c_CW-1:0] w_space;
   logic [c_CW-1:0] w_nacc;
   logic [c_CW-1:0] w_count_next;
   logic            w_drop;

   always_comb begin
      w_en       = {bus.in_en2, bus.in_en1, bus.in_en0};
      w_wdata[0] = bus.in_ret0;
      w_wdata[1] = bus.in_ret1;
      w_wdata[2] = bus.in_ret2;
      w_ndeq     = '0;
      if (bus.out_rdy) begin
         w_ndeq = (r_count >= c_TWO) ? c_TWO : r_count;
      end
      // slots released by this cycle's dequeue are reusable by this cycle's enqueue
      w_space = c_DEPTH_CNT - r_count + w_ndeq;
      w_nacc  = '0;
      w_drop  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w_wen[i]   = 1'b0;
         w_waddr[i] = r_wr_ptr + w_nacc[c_AW-1:0];
         if (w_en[i]) begin
            if (w_nacc < w_space) begin
               w_wen[i] = 1'b1;
               w_nacc   = w_nacc + c_ONE;
            end else begin
               w_drop = 1'b1;
            end
         end
      end
      w_count_next = r_count + w_nacc - w_ndeq;
   end

`ifdef swapedge
   always_ff @(negedge clk or negedge rst) begin
`else
   always_ff @(posedge clk or negedge rst) begin
`endif
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_stall  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_wen[i]) begin
               r_mem[w_waddr[i]] <= w_wdata[i];
            end
         end
         r_rd_ptr <= r_rd_ptr + w_ndeq[c_AW-1:0];
         r_wr_ptr <= r_wr_ptr + w_nacc[c_AW-1:0];
         r_count  <= w_count_next;
         // leave headroom for one more cycle of in-flight writes
         r_stall  <= (w_count_next > c_STALL_TH);
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign bus.out_vld0 = (r_count >= c_ONE);
   assign bus.out_vld1 = (r_count >= c_TWO);
   assign bus.out_ret0 = bus.out_vld0 ? r_mem[r_rd_ptr] : '0;
   assign bus.out_ret1 = bus.out_vld1 ? r_mem[r_rd_ptr + c_PTR_ONE] : '0;
   assign bus.stall    = r_stall;
   assign bus.count    = r_count;
   assign bus.ovf      = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fpsu_ret_collect.sv
`default_nettype none
// =============================================================================
// Module : tb_fpsu_ret_collect
// Brief  : Directed scoreboard bench for the retire collector.
// Rev    : 1.0  initial release
// =============================================================================
module tb_fpsu_ret_collect;
   localparam int DEPTH = 8;
   localparam int W     = 14;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   logic [W-1:0] exp_q [$];

   fpsu_ret_collect_if #(.DEPTH(DEPTH), .W(W)) bus ();

   fpsu_ret_collect #(.DEPTH(DEPTH), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [2:0] en, input logic [W-1:0] r0, input logic [W-1:0] r1,
                        input logic [W-1:0] r2, input logic rdy, input logic clr);
      bus.in_en0  = en[0];
      bus.in_en1  = en[1];
      bus.in_en2  = en[2];
      bus.in_ret0 = r0;
      bus.in_ret1 = r1;
      bus.in_ret2 = r2;
      bus.out_rdy = rdy;
      bus.clr_ovf = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard for every word the consumer takes.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && bus.out_rdy) begin
            if (bus.out_vld0) begin
               if (exp_q.size() == 0) chk("unexpected_ret0", 32'(bus.out_ret0), 32'hDEAD);
               else                   chk("ret0", 32'(bus.out_ret0), 32'(exp_q.pop_front()));
            end
            if (bus.out_vld1) begin
               if (exp_q.size() == 0) chk("unexpected_ret1", 32'(bus.out_ret1), 32'hDEAD);
               else                   chk("ret1", 32'(bus.out_ret1), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b0;
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      #2;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_vld0", 32'(bus.out_vld0), 0);
      chk("rst_vld1", 32'(bus.out_vld1), 0);
      chk("rst_stall", 32'(bus.stall), 0);
      chk("rst_ovf", 32'(bus.ovf), 0);
      chk("rst_ret0", 32'(bus.out_ret0), 0);
      step();
      step();
      rst = 1'b1;

      // Two non-adjacent ports compress into consecutive slots
      drive(3'b101, 14'h0011, 14'h3FFF, 14'h0033, 1'b0, 1'b0);
      exp_q.push_back(14'h0011);
      exp_q.push_back(14'h0033);
      #1;
      chk("no_bypass_vld0", 32'(bus.out_vld0), 0);
      step();
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      chk("t1_count", 32'(bus.count), 2);
      chk("t1_ret0", 32'(bus.out_ret0), 32'h0011);
      chk("t1_ret1", 32'(bus.out_ret1), 32'h0033);
      chk("t1_vld0", 32'(bus.out_vld0), 1);
      chk("t1_vld1", 32'(bus.out_vld1), 1);
      chk("t1_stall", 32'(bus.stall), 0);

      // Fill to seven entries
      drive(3'b111, 14'h0101, 14'h0102, 14'h0103, 1'b0, 1'b0);
      exp_q.push_back(14'h0101); exp_q.push_back(14'h0102); exp_q.push_back(14'h0103);
      step();
      chk("fill5_stall", 32'(bus.stall), 0);
      drive(3'b011, 14'h0104, 14'h0105, 14'h0000, 1'b0, 1'b0);
      exp_q.push_back(14'h0104); exp_q.push_back(14'h0105);
      step();
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      chk("fill7_count", 32'(bus.count), 7);
      chk("fill7_stall", 32'(bus.stall), 1);
      chk("fill7_ovf", 32'(bus.ovf), 0);

      // One free slot, three words offered
      drive(3'b111, 14'h000A, 14'h000B, 14'h000C, 1'b0, 1'b0);
      exp_q.push_back(14'h000A);
      step();
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      chk("ovf_count", 32'(bus.count), 8);
      chk("ovf_set", 32'(bus.ovf), 1);
      chk("ovf_stall", 32'(bus.stall), 1);

      // Full queue, dequeue two while offering three
      drive(3'b111, 14'h0021, 14'h0022, 14'h0023, 1'b1, 1'b0);
      exp_q.push_back(14'h0021); exp_q.push_back(14'h0022);
      step();
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      chk("full_deq_count", 32'(bus.count), 8);
      chk("full_deq_ovf", 32'(bus.ovf), 1);
      chk("full_deq_ret0", 32'(bus.out_ret0), 32'h0101);
      chk("full_deq_ret1", 32'(bus.out_ret1), 32'h0102);

      // Clear in the same cycle as a drop keeps ovf; clear alone releases it
      drive(3'b001, 14'h0055, 14'h0000, 14'h0000, 1'b0, 1'b1);
      step();
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      chk("clr_with_drop_ovf", 32'(bus.ovf), 1);
      chk("clr_with_drop_count", 32'(bus.count), 8);
      drive(3'b000, '0, '0, '0, 1'b0, 1'b1);
      step();
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      chk("clr_ovf", 32'(bus.ovf), 0);

      // Drain
      drive(3'b000, '0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("drain_count", 32'(bus.count), 0);
      chk("drain_stall", 32'(bus.stall), 0);
      chk("drain_vld0", 32'(bus.out_vld0), 0);

      // Streaming single words across pointer wrap
      for (int i = 0; i < 20; i++) begin
         drive(3'b001, 14'(32'h0200 + i), 14'h0000, 14'h0000, 1'b1, 1'b0);
         exp_q.push_back(14'(32'h0200 + i));
         step();
         chk("stream_count", 32'(bus.count), 1);
      end
      drive(3'b000, '0, '0, '0, 1'b1, 1'b0);
      step();
      chk("stream_end_count", 32'(bus.count), 0);
      chk("stream_ovf", 32'(bus.ovf), 0);

      // Reset mid-operation with six queued words
      drive(3'b111, 14'h0301, 14'h0302, 14'h0303, 1'b0, 1'b0);
      step();
      drive(3'b111, 14'h0304, 14'h0305, 14'h0306, 1'b0, 1'b0);
      step();
      drive(3'b000, '0, '0, '0, 1'b0, 1'b0);
      chk("pre_rst_stall", 32'(bus.stall), 1);
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_count", 32'(bus.count), 0);
      chk("midrst_vld0", 32'(bus.out_vld0), 0);
      chk("midrst_stall", 32'(bus.stall), 0);
      step();
      #2;
      rst = 1'b1;
      drive(3'b000, '0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk("post_rst_vld0", 32'(bus.out_vld0), 0);
      drive(3'b010, 14'h0000, 14'h03AA, 14'h0000, 1'b1, 1'b0);
      exp_q.push_back(14'h03AA);
      step();
      drive(3'b000, '0, '0, '0, 1'b1, 1'b0);
      step();
      step();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
